// File: rtl/regfile_mp.sv
// Two-read/one-write register file with optional write-through forwarding,
// optional hardwired-zero entry 0, and a sequential clear sweep (IDLE/CLEAR/DONE).
module regfile_mp #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_r0,
    output logic [DATA_W-1:0] data_out0,
    input  logic [ADDR_W-1:0] addr_r1,
    output logic [DATA_W-1:0] data_out1,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              wr_drop_reg;
    logic [DATA_W-1:0] mem_reg [DEPTH];

    logic              w_zero;
    logic              wr_ok;
    logic              byp_ok;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    // Writes to a hardwired-zero entry vanish entirely: no store, no forward, no drop flag.
    assign w_zero = (ZERO_R0 != 0) && (addr_w == '0);
    assign wr_ok  = we && !w_zero && ((state_reg == IDLE) || (state_reg == DONE));
    assign byp_ok = (BYPASS != 0) && we && !w_zero && (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            wr_drop_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            wr_drop_reg <= we && !w_zero && (state_reg == CLEAR);
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                ptr_next = ptr_reg + 1'b1;
                if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = DONE;
                    ptr_next   = '0;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (state_reg == CLEAR) begin
            mem_reg[ptr_reg] <= '0;
        end else if (wr_ok) begin
            mem_reg[addr_w] <= data_in;
        end
    end

    assign rd_addr[0] = addr_r0;
    assign rd_addr[1] = addr_r1;

    // Zero-entry masking takes precedence over forwarding.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            assign rd_data[gi] = ((ZERO_R0 != 0) && (rd_addr[gi] == '0)) ? '0 :
                                 (byp_ok && (addr_w == rd_addr[gi]))     ? data_in :
                                 mem_reg[rd_addr[gi]];
        end
    endgenerate

    assign data_out0 = rd_data[0];
    assign data_out1 = rd_data[1];
    assign busy      = (state_reg == CLEAR);
    assign clr_done  = (state_reg == DONE);
    assign wr_drop   = wr_drop_reg;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each register entry in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter BYPASS, default 1: 1 = write-through forwarding on read ports; 0 = none.
REQ-004 SHALL have parameter ZERO_R0, default 0: 1 = entry 0 hardwired to zero.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port addr_w  input  ADDR_W  write address.
REQ-009 SHALL have port data_in  input  DATA_W  write data.
REQ-010 SHALL have port addr_r0  input  ADDR_W  read port 0 address.
REQ-011 SHALL have port data_out0  output  DATA_W  read port 0 data, combinational.
REQ-012 SHALL have port addr_r1  input  ADDR_W  read port 1 address.
REQ-013 SHALL have port data_out1  output  DATA_W  read port 1 data, combinational.
REQ-014 SHALL have port clr_req  input  1  request a sequential clear of all entries.
REQ-015 SHALL have port busy  output  1  high while a clear sweep is in progress.
REQ-016 SHALL have port clr_done  output  1  one-cycle pulse when a clear completes.
REQ-017 SHALL have port wr_drop  output  1  one-cycle pulse flagging a write discarded by a clear.

Function
REQ-018 Write SHALL be synchronous: with we=1 and state IDLE, entry addr_w takes data_in at the rising edge.
REQ-019 Reads SHALL be asynchronous and independent; both ports may address the same entry.
REQ-020 With BYPASS=1, and we=1, state IDLE, addr_w==addr_rN, data_outN SHALL equal data_in in the same cycle; with BYPASS=0 it SHALL show the old value until after the edge.
REQ-021 With ZERO_R0=1, reads of address 0 SHALL return 0, and writes to address 0 SHALL be discarded silently (no bypass, no wr_drop).
REQ-022 FSM states SHALL be IDLE, CLEAR, DONE; reset state IDLE.
REQ-023 IDLE: clr_req=1 -> CLEAR with sweep pointer ptr=0; otherwise stay IDLE.
REQ-024 CLEAR: each cycle entry[ptr] <= 0 and ptr <= ptr+1; when ptr==DEPTH-1 -> DONE; exactly DEPTH cycles in CLEAR.
REQ-025 DONE: clr_done=1 for that single cycle, then -> IDLE unconditionally.
REQ-026 busy SHALL equal 1 exactly while in CLEAR.
REQ-027 clr_req SHALL be ignored in CLEAR and DONE (no restart, no queuing).
REQ-028 we=1 during CLEAR SHALL not modify any entry and SHALL raise wr_drop on the following cycle for one cycle per dropped write; writes in DONE SHALL be performed normally.
REQ-029 we=1 and clr_req=1 in the same IDLE cycle: write SHALL be performed, then the sweep clears it.
REQ-030 Reads during CLEAR SHALL return stored contents (cleared entries read 0, not-yet-cleared entries read old data); no bypass during CLEAR.
REQ-031 ptr SHALL be ADDR_W bits; no wrap beyond DEPTH-1 within one sweep.

Reset
REQ-032 rst_n=0 SHALL immediately set all entries to 0, state IDLE, ptr=0, busy=0, clr_done=0, wr_drop=0, independent of clk.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep; after release the block is IDLE with all entries 0.
REQ-034 First write SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Defaults: write 0xA5 to addr 3, next cycle read addr 3 on both ports -> 0xA5 on data_out0 and data_out1.
REQ-036 BYPASS=1: we=1, addr_w=5, data_in=0x3C, addr_r0=5 same cycle -> data_out0=0x3C before the edge; BYPASS=0 -> old value (0x00 after reset).
REQ-037 Fill all 16 entries with 0x10+i, pulse clr_req -> busy high exactly 16 cycles, clr_done pulse on cycle 17, all entries read 0x00.
REQ-038 we=1 to addr 7 with 0xFF at cycle 4 of a sweep -> entry 7 stays 0x00, wr_drop pulses once next cycle.
REQ-039 ZERO_R0=1: write 0x77 to addr 0 -> read addr 0 returns 0x00, wr_drop stays 0.
REQ-040 Assert rst_n=0 at cycle 8 of a sweep with entries pre-filled -> busy drops immediately, all entries 0x00, no clr_done pulse.
